// File: rtl/memory_unit_pkg.sv
// Shared types and defaults for the A/D/M storage block.
package memory_unit_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 13;
  localparam int DEPTH_DEF  = 8192;

  // Index width needed to address DEPTH words (at least one bit).
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/memory_unit_if.sv
// CPU-side bus of the memory unit: operands, enables, read strobe and stall.
interface memory_unit_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13
);
  logic [ADDR_W-1:0] addr;
  logic              reg_a_en;
  logic              reg_d_en;
  logic              reg_m_en;
  logic              m_rd_req;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] reg_a_out;
  logic [DATA_W-1:0] reg_d_out;
  logic [DATA_W-1:0] reg_m_out;
  logic              m_valid;
  logic              busy;

  modport master (
    output addr, reg_a_en, reg_d_en, reg_m_en, m_rd_req, data_in,
    input  reg_a_out, reg_d_out, reg_m_out, m_valid, busy
  );

  modport slave (
    input  addr, reg_a_en, reg_d_en, reg_m_en, m_rd_req, data_in,
    output reg_a_out, reg_d_out, reg_m_out, m_valid, busy
  );
endinterface

// File: rtl/memory_unit_ram.sv
// Single-port synchronous RAM, write-first, registered read.
module memory_unit_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 8192
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Write port plus registered read; a write returns the new data on the read port.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
      rdata       <= wdata;
    end else begin
      rdata <= r_mem[addr];
    end
  end

endmodule

// File: rtl/memory_unit.sv
// A/D registers plus data RAM M with a post-reset clear sequencer.
module memory_unit
  import memory_unit_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DEPTH          = DEPTH_DEF,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  memory_unit_if.slave bus
);

  localparam int              IDX_W     = idx_w(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_L  = ADDR_W'(DEPTH - 1);
  localparam state_t          RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_d;
  logic [DATA_W-1:0] r_m_hold;
  logic              r_valid;
  logic              r_oor;
  logic              r_busy;

  logic              w_idle;
  logic              w_oor;
  logic              w_we;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] w_m_out;

  // State register: reset picks clear or idle depending on CLEAR_ON_RESET.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= RST_STATE;
    else        r_state <= w_state_next;
  end

  // Next state: leave CLEAR once the last word is being written.
  always_comb begin
    w_state_next = r_state;
    if (r_state == ST_CLEAR && r_cnt == LAST_L) w_state_next = ST_IDLE;
  end

  // Outputs: RAM port is owned by the clear counter in CLEAR, by the CPU in IDLE.
  always_comb begin
    w_idle = (r_state == ST_IDLE);
    w_oor  = ({1'b0, bus.addr} >= DEPTH_L);
    if (w_idle) begin
      w_we       = rst_n & bus.reg_m_en & ~w_oor;
      w_ram_addr = bus.addr;
      w_wdata    = bus.data_in;
    end else begin
      w_we       = rst_n;
      w_ram_addr = r_cnt;
      w_wdata    = '0;
    end
  end

  // Clear counter: advances through the RAM and parks on the last word.
  always_ff @(posedge clk) begin
    if (!rst_n)                                 r_cnt <= '0;
    else if (r_state == ST_CLEAR && r_cnt != LAST_L) r_cnt <= r_cnt + 1'b1;
  end

  // Busy: high through reset and every clear cycle, low from the first idle cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) r_busy <= 1'b1;
    else        r_busy <= (w_state_next == ST_CLEAR);
  end

  // A and D load from data_in only when idle; enables during clear are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a <= '0;
      r_d <= '0;
    end else begin
      if (w_idle && bus.reg_a_en) r_a <= bus.data_in;
      if (w_idle && bus.reg_d_en) r_d <= bus.data_in;
    end
  end

  // Read pipeline: valid strobe and out-of-range flag travel alongside the RAM read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_oor   <= 1'b0;
    end else begin
      r_valid <= w_idle & bus.m_rd_req;
      r_oor   <= w_oor;
    end
  end

  // Hold register keeps the last read result, since the RAM output moves every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)       r_m_hold <= '0;
    else if (r_valid) r_m_hold <= w_m_out;
  end

  assign w_m_out = r_valid ? (r_oor ? '0 : w_rdata) : r_m_hold;

  memory_unit_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (IDX_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (w_we),
    .addr  (w_ram_addr[IDX_W-1:0]),
    .wdata (w_wdata),
    .rdata (w_rdata)
  );

  assign bus.reg_a_out = r_a;
  assign bus.reg_d_out = r_d;
  assign bus.reg_m_out = w_m_out;
  assign bus.m_valid   = r_valid;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_memory_unit.sv
// Directed bench for memory_unit: clear sequence, A/D loads, M reads/writes, range checks.
module tb_memory_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  memory_unit_if #(.DATA_W(16), .ADDR_W(4)) if0 ();
  memory_unit_if #(.DATA_W(16), .ADDR_W(4)) if1 ();
  memory_unit_if #(.DATA_W(16), .ADDR_W(4)) if2 ();

  memory_unit #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .CLEAR_ON_RESET(1'b1))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  memory_unit #(.DATA_W(16), .ADDR_W(4), .DEPTH(12), .CLEAR_ON_RESET(1'b1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  memory_unit #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .CLEAR_ON_RESET(1'b0))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic quiet_all();
    if0.addr = '0; if0.reg_a_en = 0; if0.reg_d_en = 0; if0.reg_m_en = 0; if0.m_rd_req = 0; if0.data_in = '0;
    if1.addr = '0; if1.reg_a_en = 0; if1.reg_d_en = 0; if1.reg_m_en = 0; if1.m_rd_req = 0; if1.data_in = '0;
    if2.addr = '0; if2.reg_a_en = 0; if2.reg_d_en = 0; if2.reg_m_en = 0; if2.m_rd_req = 0; if2.data_in = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   n;
    logic bad_valid;
    logic bad_a;
    logic b2;

    rst_n = 1'b0;
    quiet_all();
    repeat (3) step();
    chk("reset_a", if0.reg_a_out, 0);
    chk("reset_d", if0.reg_d_out, 0);
    chk("reset_mout", if0.reg_m_out, 0);
    chk("reset_valid", if0.m_valid, 0);
    chk("reset_busy", if0.busy, 1);
    chk("cor0_busy_in_reset", if2.busy, 1);

    // Clear sequence with read and A-load requests hammering the whole time
    if0.reg_a_en = 1; if0.data_in = 16'h4242; if0.m_rd_req = 1; if0.addr = 4'd3;
    rst_n = 1'b1;
    n = 0; bad_valid = 0; bad_a = 0; b2 = 1;
    while (if0.busy === 1'b1 && n < 100) begin
      n++;
      if (if0.m_valid !== 1'b0) bad_valid = 1;
      if (if0.reg_a_out !== 16'h0) bad_a = 1;
      step();
      if (n == 1) b2 = if2.busy;
    end
    quiet_all();
    chk("clear_busy_cycles", n, 16);
    chk("clear_no_valid", bad_valid, 0);
    chk("clear_a_held", bad_a, 0);
    chk("clear_valid_after", if0.m_valid, 0);
    chk("clear_a_after", if0.reg_a_out, 0);
    chk("cor0_busy_after_release", b2, 0);
    chk("dut1_idle", if1.busy, 0);

    // First idle read returns the cleared word
    if0.addr = 4'd5; if0.m_rd_req = 1;
    step();
    if0.m_rd_req = 0;
    chk("rd5_valid", if0.m_valid, 1);
    chk("rd5_data", if0.reg_m_out, 16'h0000);
    step();
    chk("rd5_valid_drop", if0.m_valid, 0);

    // A and D loads
    if0.reg_a_en = 1; if0.reg_d_en = 1; if0.data_in = 16'hBEEF;
    step();
    quiet_all();
    chk("ad_load_a", if0.reg_a_out, 16'hBEEF);
    chk("ad_load_d", if0.reg_d_out, 16'hBEEF);
    if0.reg_d_en = 1; if0.data_in = 16'h1234;
    step();
    quiet_all();
    chk("d_only_d", if0.reg_d_out, 16'h1234);
    chk("d_only_a", if0.reg_a_out, 16'hBEEF);

    // Write then read back, then hold
    if0.reg_m_en = 1; if0.addr = 4'd7; if0.data_in = 16'hA5A5;
    step();
    quiet_all();
    if0.m_rd_req = 1; if0.addr = 4'd7;
    step();
    quiet_all();
    chk("rd7_valid", if0.m_valid, 1);
    chk("rd7_data", if0.reg_m_out, 16'hA5A5);
    if0.data_in = 16'h5555;
    step();
    chk("rd7_valid_drop", if0.m_valid, 0);
    chk("rd7_hold", if0.reg_m_out, 16'hA5A5);

    // Same-cycle read and write: write-first
    if0.reg_m_en = 1; if0.addr = 4'd9; if0.data_in = 16'h1111;
    step();
    if0.data_in = 16'h0F0F; if0.m_rd_req = 1;
    step();
    quiet_all();
    chk("rw9_valid", if0.m_valid, 1);
    chk("rw9_data", if0.reg_m_out, 16'h0F0F);

    // Back-to-back reads, in order, plus a write elsewhere in the same cycle
    if0.m_rd_req = 1; if0.addr = 4'd7;
    step();
    chk("b2b_first", if0.reg_m_out, 16'hA5A5);
    if0.addr = 4'd9;
    step();
    quiet_all();
    chk("b2b_second", if0.reg_m_out, 16'h0F0F);
    chk("b2b_second_valid", if0.m_valid, 1);

    // Out-of-range on DEPTH=12
    if1.reg_m_en = 1; if1.addr = 4'd1; if1.data_in = 16'h3333;
    step();
    if1.addr = 4'd13; if1.data_in = 16'h7777;
    step();
    quiet_all();
    if1.m_rd_req = 1; if1.addr = 4'd13;
    step();
    chk("oor_valid", if1.m_valid, 1);
    chk("oor_data", if1.reg_m_out, 0);
    if1.addr = 4'd1;
    step();
    quiet_all();
    chk("oor_rd1", if1.reg_m_out, 16'h3333);

    // No-clear variant is usable immediately
    if2.reg_m_en = 1; if2.addr = 4'd4; if2.data_in = 16'h5A5A;
    step();
    quiet_all();
    if2.m_rd_req = 1; if2.addr = 4'd4;
    step();
    quiet_all();
    chk("cor0_rd4", if2.reg_m_out, 16'h5A5A);

    // Reset in the middle of a clear restarts it in full
    if0.reg_m_en = 1; if0.addr = 4'd2; if0.data_in = 16'hCAFE;
    step();
    quiet_all();
    if0.m_rd_req = 1; if0.addr = 4'd2;
    step();
    quiet_all();
    chk("pre_rst_rd2", if0.reg_m_out, 16'hCAFE);
    rst_n = 1'b0;
    step();
    chk("rst2_a", if0.reg_a_out, 0);
    chk("rst2_d", if0.reg_d_out, 0);
    chk("rst2_mout", if0.reg_m_out, 0);
    chk("rst2_busy", if0.busy, 1);
    rst_n = 1'b1;
    repeat (8) step();
    chk("mid_clear_busy", if0.busy, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n = 0;
    while (if0.busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
    chk("reclear_busy_cycles", n, 16);
    if0.m_rd_req = 1; if0.addr = 4'd2;
    step();
    if0.addr = 4'd7;
    chk("post_clear_rd2", if0.reg_m_out, 0);
    step();
    quiet_all();
    chk("post_clear_rd7", if0.reg_m_out, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
